// File: rtl/axis_fft_out_framer.sv
`default_nettype none
// ============================================================================
// axis_fft_out_framer : buffers packed FFT samples, frames them with tlast every
// FRAME_LEN beats and flags upstream tlast misalignment. Optional macro
// FFT_BITREV_EN swaps the FIFO for a frame RAM that restores natural order.
// Revision: 1.0
// ============================================================================
module axis_fft_out_framer #(
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_areset,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic [15:0]         frame_cnt,
  output logic                tlast_err
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic              s_fire;
  logic              m_fire;
  logic              at_last;
  logic              src_valid;
  logic              src_last;
  logic              out_load;
  logic [DATA_W-1:0] src_data;
  logic [CNT_W-1:0]  beat_cnt;

  assign s_fire       = s_axis_tvalid && s_axis_tready;
  assign m_fire       = m_axis_tvalid && m_axis_tready;
  assign at_last      = (beat_cnt == LAST_BEAT);
  assign out_load     = src_valid && (!m_axis_tvalid || m_axis_tready);
  assign m_axis_tkeep = '1;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      beat_cnt  <= '0;
      tlast_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (s_fire) begin
        if (s_axis_tlast != at_last) tlast_err <= 1'b1;
        beat_cnt <= s_axis_tlast ? '0 : beat_cnt + CNT_W'(1);
      end
      if (m_fire && m_axis_tlast) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Output register: holds while stalled, reloads from the buffer head.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= src_data;
      m_axis_tlast  <= src_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef FFT_BITREV_EN
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] frame_ram [FRAME_LEN];
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  wr_addr;
  logic [CNT_W-1:0]  rd_addr;
  logic              rd_done;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_issue;

  always_comb begin
    wr_addr = '0;
    for (int b = 0; b < CNT_W; b++) wr_addr[b] = beat_cnt[CNT_W-1-b];
  end

  assign rd_issue  = (state == DRAIN) && !rd_done && (!rd_valid || out_load);
  assign src_valid = rd_valid;
  assign src_data  = rd_data;
  assign src_last  = rd_last;

  always_ff @(posedge s_axis_aclk) begin
    if (s_fire) frame_ram[wr_addr] <= s_axis_tdata;
    if (rd_issue) rd_data <= frame_ram[rd_addr];
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state         <= FILL;
      s_axis_tready <= 1'b0;
      rd_addr       <= '0;
      rd_done       <= 1'b0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          s_axis_tready <= 1'b1;
          if (s_fire && at_last) begin
            state         <= DRAIN;
            s_axis_tready <= 1'b0;
            rd_addr       <= '0;
            rd_done       <= 1'b0;
          end
        end
        DRAIN: begin
          if (rd_issue) begin
            rd_valid <= 1'b1;
            rd_last  <= (rd_addr == LAST_BEAT);
            rd_addr  <= rd_addr + CNT_W'(1);
            if (rd_addr == LAST_BEAT) rd_done <= 1'b1;
          end else if (out_load) begin
            rd_valid <= 1'b0;
          end
          if (m_fire && m_axis_tlast) begin
            state         <= FILL;
            s_axis_tready <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     mem_cnt;
  logic [AW:0]     occ;
  logic [AW:0]     occ_next;

  assign src_valid            = (mem_cnt != '0);
  assign {src_last, src_data} = fifo_mem[rd_ptr];

  // Occupancy includes the output register so total storage is FIFO_DEPTH.
  always_comb begin
    occ_next = occ;
    if (s_fire && !m_fire)      occ_next = occ + (AW+1)'(1);
    else if (!s_fire && m_fire) occ_next = occ - (AW+1)'(1);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_fire) fifo_mem[wr_ptr] <= {at_last, s_axis_tdata};
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      occ           <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      if (s_fire)   wr_ptr <= wr_ptr + AW'(1);
      if (out_load) rd_ptr <= rd_ptr + AW'(1);
      if (s_fire && !out_load)      mem_cnt <= mem_cnt + (AW+1)'(1);
      else if (!s_fire && out_load) mem_cnt <= mem_cnt - (AW+1)'(1);
      occ           <= occ_next;
      s_axis_tready <= (occ_next != (AW+1)'(FIFO_DEPTH));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_fft_out_framer.sv
`default_nettype none
// Bench for axis_fft_out_framer: random stimulus, queue scoreboard fed by a
// frame-level reference model, independent output monitor.
module tb_axis_fft_out_framer;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 128;
  localparam int LOGN      = $clog2(FRAME_LEN);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic                s_last;
  logic                m_valid;
  logic                m_ready;
  logic [DATA_W-1:0]   m_data;
  logic                m_last;
  logic [DATA_W/8-1:0] m_keep;
  logic [15:0]         frame_cnt;
  logic                tlast_err;

  always #5 clk = ~clk;

  axis_fft_out_framer #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(16)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tkeep  (m_keep),
    .frame_cnt     (frame_cnt),
    .tlast_err     (tlast_err)
  );

  int                checks = 0;
  int                errors = 0;
  logic [DATA_W:0]   exp_q[$];
  int                m_cnt = 0;
  bit                exp_err = 1'b0;
  int                exp_frames = 0;
  logic [DATA_W-1:0] frame_buf [FRAME_LEN];
  bit                in_drain = 1'b0;
  bit                rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    for (int b = 0; b < LOGN; b++) if (k & (1 << b)) r |= 1 << (LOGN - 1 - b);
    return r;
  endfunction

  // Reference model: frame position counter, sticky error, expected output order.
  function automatic void model_accept(input logic [DATA_W-1:0] d, input bit tl);
    bit at_end;
    at_end = (m_cnt == FRAME_LEN - 1);
    if (tl != at_end) exp_err = 1'b1;
`ifdef FFT_BITREV_EN
    frame_buf[bitrev(m_cnt)] = d;
    if (at_end) begin
      for (int n = 0; n < FRAME_LEN; n++) exp_q.push_back({n == FRAME_LEN - 1, frame_buf[n]});
      in_drain = 1'b1;
    end
`else
    exp_q.push_back({at_end, d});
`endif
    m_cnt = tl ? 0 : (m_cnt + 1) % FRAME_LEN;
  endfunction

  task automatic send(input logic [DATA_W-1:0] d, input bit tl);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = tl;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(d, tl);
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 2000) begin
        check("send_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [DATA_W:0] req;
    logic [DATA_W:0] held;
    bit stalled;
    bit drain_seen;
    stalled    = 1'b0;
    drain_seen = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled    = 1'b0;
        drain_seen = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", m_valid, 1);
          check("stall_beat", {m_last, m_data}, held);
        end
`ifdef FFT_BITREV_EN
        if (drain_seen) check("drain_tready", s_ready, 0);
`endif
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h, required no beat", m_data);
          end else begin
            req = exp_q.pop_front();
            check("out_beat", {m_last, m_data}, req);
            if (req[DATA_W]) begin
              exp_frames++;
              in_drain = 1'b0;
            end
          end
        end
        stalled    = m_valid && !m_ready;
        held       = {m_last, m_data};
        drain_seen = in_drain;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    #12;
    check("rst_tready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_mlast", m_last, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_tlast_err", tlast_err, 0);
    check("tkeep", m_keep, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    check("tready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    check("tready_after_edge", s_ready, 1);

    // Aligned frame at full rate.
    m_ready = 1'b1;
`ifdef FFT_BITREV_EN
    for (int k = 0; k < FRAME_LEN; k++) send(DATA_W'(bitrev(k)), k == FRAME_LEN - 1);
    @(negedge clk); check("lat_edge1", m_valid, 0);
    @(negedge clk); check("lat_edge2", m_valid, 0);
    @(negedge clk); check("lat_edge3", m_valid, 1);
`else
    for (int k = 0; k < FRAME_LEN; k++) send(DATA_W'(k), k == FRAME_LEN - 1);
`endif
    wait_drain("drain_frame1");
    check("frame_cnt_1", frame_cnt, 16'(exp_frames));
    check("tlast_err_1", tlast_err, exp_err);

`ifndef FFT_BITREV_EN
    // Backpressure: 20 offered beats against a stalled sink.
    m_ready = 1'b0;
    acc     = 0;
    s_valid = 1'b1;
    s_last  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_data = DATA_W'(acc);
      @(negedge clk);
      if (c == 16) check("tready_full", s_ready, 0);
      if (s_ready) begin
        model_accept(DATA_W'(acc), 1'b0);
        acc++;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("accepted_when_full", acc, 16);
    m_ready = 1'b1;
    for (int k = 16; k < FRAME_LEN; k++) send($urandom, k == FRAME_LEN - 1);
    wait_drain("drain_backpressure");
    check("frame_cnt_bp", frame_cnt, 16'(exp_frames));
    check("tlast_err_bp", tlast_err, exp_err);
`endif

    // Early upstream tlast on beat 63, then an aligned frame.
    for (int k = 0; k < 64; k++) send($urandom, k == 63);
    for (int k = 0; k < FRAME_LEN; k++) send($urandom, k == FRAME_LEN - 1);
    wait_drain("drain_resync");
    check("tlast_err_resync", tlast_err, exp_err);
    check("frame_cnt_resync", frame_cnt, 16'(exp_frames));

    // Three frames with random sink stalls and source gaps.
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        send($urandom, k == FRAME_LEN - 1);
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
    end
    wait_drain("drain_random");
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    check("frame_cnt_random", frame_cnt, 16'(exp_frames));

    // Reset with beats still buffered.
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) send($urandom, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_mvalid", m_valid, 0);
    check("midrst_tready", s_ready, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_tlast_err", tlast_err, 0);
    exp_q.delete();
    m_cnt      = 0;
    exp_err    = 1'b0;
    exp_frames = 0;
    in_drain   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < FRAME_LEN; k++) send($urandom, k == FRAME_LEN - 1);
    wait_drain("drain_after_reset");
    check("frame_cnt_after_reset", frame_cnt, 16'(exp_frames));
    check("tlast_err_after_reset", tlast_err, exp_err);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
